// File: rtl/mmio_bram_port_if.sv
// Request/response bus between the load/store unit and one BRAM-backed MMIO region.
interface mmio_bram_port_if #(
   parameter int DATA_WIDTH = 32
);
   localparam int BYTES = DATA_WIDTH / 8;

   logic                  memRequest;
   logic                  memReady;
   logic [31:0]           memAddress;
   logic                  memWrite;
   logic [DATA_WIDTH-1:0] memWriteData;
   logic [BYTES-1:0]      byteMask;
   logic                  memSelected;
   logic                  memDone;
   logic                  memError;
   logic [DATA_WIDTH-1:0] memReadData;

   modport master (
      output memRequest, memAddress, memWrite, memWriteData, byteMask,
      input  memReady, memSelected, memDone, memError, memReadData
   );

   modport slave (
      input  memRequest, memAddress, memWrite, memWriteData, byteMask,
      output memReady, memSelected, memDone, memError, memReadData
   );
endinterface

// File: rtl/mmio_bram_port.sv
// Memory-mapped block-RAM slave: valid/ready request, one-cycle done pulse,
// configurable read latency, error response for out-of-window or misaligned access.
module mmio_bram_port #(
   parameter int          DATA_WIDTH   = 32,
   parameter logic [31:0] BASE_MEMORY  = 32'h0000_0000,
   parameter logic [31:0] TOP_MEMORY   = 32'h0000_01ff,
   parameter int          READ_LATENCY = 1,
   parameter string       INIT_FILE    = ""
) (
   input  logic            clk,
   input  logic            resetn,
   mmio_bram_port_if.slave bus
);
   localparam int          BYTES     = DATA_WIDTH / 8;
   localparam int          OFFS_W    = $clog2(BYTES);
   localparam logic [31:0] LAST_OFF  = TOP_MEMORY - BASE_MEMORY;
   localparam int          DEPTH     = int'(LAST_OFF + 32'd1) / BYTES;
   localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int          PIPE_N    = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;
   localparam int          PIPE_LAST = PIPE_N - 1;
   localparam logic [1:0]  CNT_INIT  = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

   state_e                           state_q, state_d;
   logic [1:0]                       cnt_q, cnt_d;
   logic                             err_q, err_d;
   logic [DATA_WIDTH-1:0]            rdata_q, rdata_d;
   logic [PIPE_N-1:0][DATA_WIDTH-1:0] rd_pipe_q, rd_pipe_d;

   logic [DATA_WIDTH-1:0] mem_array [DEPTH];

   logic [31:0]      offset;
   logic [IDX_W-1:0] word_idx;
   logic             in_window;
   logic             misaligned;
   logic             good;
   logic             ready;
   logic             accept;
   logic             wr_en;
   logic             rd_good;

   // Address an unsigned offset from the base; addresses below the base wrap
   // to a large offset, so one compare covers both window edges.
   assign offset     = bus.memAddress - BASE_MEMORY;
   assign word_idx   = IDX_W'(offset >> OFFS_W);
   assign in_window  = (offset <= LAST_OFF);
   assign misaligned = |bus.memAddress[OFFS_W-1:0];
   assign good       = in_window && !misaligned;

   assign ready   = (state_q == IDLE) || (state_q == DONE);
   assign accept  = bus.memRequest && ready && resetn;
   assign wr_en   = accept && good && bus.memWrite;
   assign rd_good = accept && good && !bus.memWrite;

   assign bus.memReady    = ready;
   assign bus.memSelected = in_window;
   assign bus.memDone     = (state_q == DONE);
   assign bus.memError    = err_q;
   assign bus.memReadData = rdata_q;

   // Byte-masked write committed at the accepting edge.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < BYTES; i++) begin
            if (bus.byteMask[i]) mem_array[word_idx][8*i +: 8] <= bus.memWriteData[8*i +: 8];
         end
      end
   end

   // Read pipeline: stage 0 captures the array on accept, later stages shift.
   always_comb begin
      rd_pipe_d = rd_pipe_q;
      if (rd_good) rd_pipe_d[0] = mem_array[word_idx];
      for (int i = 1; i < PIPE_N; i++) rd_pipe_d[i] = rd_pipe_q[i-1];
   end

   // Read pipeline registers carry data only and need no reset.
   always_ff @(posedge clk) begin
      rd_pipe_q <= rd_pipe_d;
   end

   // Next-state, latency counter, error flag and read-data selection.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               err_d = !good;
               if (bus.memWrite) begin
                  state_d = DONE;
               end else if (!good) begin
                  state_d = DONE;
                  rdata_d = '0;
               end else if (READ_LATENCY == 1) begin
                  state_d = DONE;
                  rdata_d = mem_array[word_idx];
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (cnt_q == 2'd0) begin
               state_d = DONE;
               rdata_d = rd_pipe_q[PIPE_LAST];
            end else begin
               cnt_d = 2'(cnt_q - 2'd1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end
endmodule

// File: tb/tb_mmio_bram_port.sv
// Directed bench for mmio_bram_port: table-driven vectors on a latency-1 port,
// hand sequences for latency 3/4, reset corners and a 64-bit window.
module tb_mmio_bram_port;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rn1, rn3, rn4, rn64;
   int   n_vec = 0;
   int   n_bad = 0;

   mmio_bram_port_if #(.DATA_WIDTH(32)) b1 ();
   mmio_bram_port_if #(.DATA_WIDTH(32)) b3 ();
   mmio_bram_port_if #(.DATA_WIDTH(32)) b4 ();
   mmio_bram_port_if #(.DATA_WIDTH(64)) b64 ();

   mmio_bram_port #(.DATA_WIDTH(32), .BASE_MEMORY(32'h0), .TOP_MEMORY(32'h1ff),
                    .READ_LATENCY(1), .INIT_FILE(""))
      u1 (.clk(clk), .resetn(rn1), .bus(b1));
   mmio_bram_port #(.DATA_WIDTH(32), .BASE_MEMORY(32'h0), .TOP_MEMORY(32'h1ff),
                    .READ_LATENCY(3), .INIT_FILE(""))
      u3 (.clk(clk), .resetn(rn3), .bus(b3));
   mmio_bram_port #(.DATA_WIDTH(32), .BASE_MEMORY(32'h0), .TOP_MEMORY(32'h1ff),
                    .READ_LATENCY(4), .INIT_FILE(""))
      u4 (.clk(clk), .resetn(rn4), .bus(b4));
   mmio_bram_port #(.DATA_WIDTH(64), .BASE_MEMORY(32'h1000), .TOP_MEMORY(32'h10ff),
                    .READ_LATENCY(1), .INIT_FILE(""))
      u64 (.clk(clk), .resetn(rn64), .bus(b64));

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
      logic        sel;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   localparam int NV = 14;
   vec_t tbl [NV];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   initial begin
      logic seen;
      // idle all masters, hold every DUT in reset
      b1.memRequest = 0; b1.memWrite = 0; b1.memAddress = 0; b1.memWriteData = 0; b1.byteMask = 0;
      b3.memRequest = 0; b3.memWrite = 0; b3.memAddress = 0; b3.memWriteData = 0; b3.byteMask = 0;
      b4.memRequest = 0; b4.memWrite = 0; b4.memAddress = 0; b4.memWriteData = 0; b4.byteMask = 0;
      b64.memRequest = 0; b64.memWrite = 0; b64.memAddress = 0; b64.memWriteData = 0; b64.byteMask = 0;
      rn1 = 0; rn3 = 0; rn4 = 0; rn64 = 0;
      tick(); tick();
      rn1 = 1; rn3 = 1; rn4 = 1; rn64 = 1;
      tick();

      chk("rst ready", 64'(b1.memReady), 64'd1);
      chk("rst done", 64'(b1.memDone), 64'd0);
      chk("rst err", 64'(b1.memError), 64'd0);
      chk("rst rdata", 64'(b1.memReadData), 64'd0);

      //           wr    addr          wdata          mask  sel   err   rdata after done
      tbl[0]  = '{1'b1, 32'h000, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h00000000};
      tbl[1]  = '{1'b0, 32'h000, 32'h0,        4'h0, 1'b1, 1'b0, 32'hDEADBEEF};
      tbl[2]  = '{1'b1, 32'h004, 32'h12345678, 4'hF, 1'b1, 1'b0, 32'hDEADBEEF};
      tbl[3]  = '{1'b1, 32'h004, 32'h000000FF, 4'h1, 1'b1, 1'b0, 32'hDEADBEEF};
      tbl[4]  = '{1'b0, 32'h004, 32'h0,        4'hF, 1'b1, 1'b0, 32'h123456FF};
      tbl[5]  = '{1'b1, 32'h004, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b0, 32'h123456FF};
      tbl[6]  = '{1'b0, 32'h004, 32'h0,        4'h0, 1'b1, 1'b0, 32'h123456FF};
      tbl[7]  = '{1'b0, 32'h200, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00000000};
      tbl[8]  = '{1'b1, 32'h204, 32'h55555555, 4'hF, 1'b0, 1'b1, 32'h00000000};
      tbl[9]  = '{1'b0, 32'h000, 32'h0,        4'h0, 1'b1, 1'b0, 32'hDEADBEEF};
      tbl[10] = '{1'b0, 32'h002, 32'h0,        4'h0, 1'b1, 1'b1, 32'h00000000};
      tbl[11] = '{1'b1, 32'h1FC, 32'h0A0B0C0D, 4'hF, 1'b1, 1'b0, 32'h00000000};
      tbl[12] = '{1'b0, 32'h1FC, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0A0B0C0D};
      tbl[13] = '{1'b1, 32'h1FE, 32'h99999999, 4'hF, 1'b1, 1'b1, 32'h0A0B0C0D};

      for (int i = 0; i < NV; i++) begin
         b1.memRequest = 1; b1.memWrite = tbl[i].wr; b1.memAddress = tbl[i].addr;
         b1.memWriteData = tbl[i].wdata; b1.byteMask = tbl[i].mask;
         #1;
         chk($sformatf("v%0d sel", i), 64'(b1.memSelected), 64'(tbl[i].sel));
         chk($sformatf("v%0d ready", i), 64'(b1.memReady), 64'd1);
         tick();
         b1.memRequest = 0; b1.memAddress = 32'hFFFF_FFF0; b1.memWriteData = 32'h0;
         chk($sformatf("v%0d done", i), 64'(b1.memDone), 64'd1);
         chk($sformatf("v%0d err", i), 64'(b1.memError), 64'(tbl[i].err));
         chk($sformatf("v%0d rdata", i), 64'(b1.memReadData), 64'(tbl[i].rdata));
         tick();
         chk($sformatf("v%0d pulse", i), 64'(b1.memDone), 64'd0);
      end

      // reset coinciding with a write accept: nothing committed
      rn1 = 0;
      b1.memRequest = 1; b1.memWrite = 1; b1.memAddress = 32'h000;
      b1.memWriteData = 32'h11111111; b1.byteMask = 4'hF;
      tick();
      rn1 = 1; b1.memRequest = 0;
      chk("rstwr done", 64'(b1.memDone), 64'd0);
      chk("rstwr rdata", 64'(b1.memReadData), 64'd0);
      b1.memRequest = 1; b1.memWrite = 0; b1.memAddress = 32'h000;
      tick();
      b1.memRequest = 0;
      chk("rstwr readback", 64'(b1.memReadData), 64'hDEADBEEF);

      // latency 3: write then read, ready low two cycles, done on third
      b3.memRequest = 1; b3.memWrite = 1; b3.memAddress = 32'h008;
      b3.memWriteData = 32'hAABBCCDD; b3.byteMask = 4'hF;
      tick();
      b3.memRequest = 0;
      chk("l3 wr done", 64'(b3.memDone), 64'd1);
      tick();
      b3.memRequest = 1; b3.memWrite = 0; b3.memAddress = 32'h008;
      tick();
      b3.memRequest = 0;
      chk("l3 c1 ready", 64'(b3.memReady), 64'd0);
      chk("l3 c1 done", 64'(b3.memDone), 64'd0);
      tick();
      chk("l3 c2 ready", 64'(b3.memReady), 64'd0);
      chk("l3 c2 done", 64'(b3.memDone), 64'd0);
      tick();
      chk("l3 c3 done", 64'(b3.memDone), 64'd1);
      chk("l3 c3 ready", 64'(b3.memReady), 64'd1);
      chk("l3 c3 err", 64'(b3.memError), 64'd0);
      chk("l3 c3 rdata", 64'(b3.memReadData), 64'hAABBCCDD);
      tick();
      chk("l3 pulse", 64'(b3.memDone), 64'd0);

      // back-to-back writes, each accepted in the previous DONE cycle
      for (int k = 0; k < 3; k++) begin
         b3.memRequest = 1; b3.memWrite = 1; b3.memAddress = 32'h00C + 32'(4 * k);
         b3.memWriteData = 32'h11111111 * 32'(k + 1); b3.byteMask = 4'hF;
         tick();
         chk($sformatf("b2b w%0d done", k), 64'(b3.memDone), 64'd1);
      end
      b3.memRequest = 0;
      tick();
      chk("b2b idle", 64'(b3.memDone), 64'd0);
      b3.memRequest = 1; b3.memWrite = 0; b3.memAddress = 32'h010;
      tick();
      b3.memRequest = 0;
      tick(); tick();
      chk("b2b rd done", 64'(b3.memDone), 64'd1);
      chk("b2b rd data", 64'(b3.memReadData), 64'h22222222);

      // latency 4: full read, then a read aborted by reset in WAIT
      b4.memRequest = 1; b4.memWrite = 1; b4.memAddress = 32'h010;
      b4.memWriteData = 32'h55667788; b4.byteMask = 4'hF;
      tick();
      b4.memRequest = 0;
      tick();
      b4.memRequest = 1; b4.memWrite = 0; b4.memAddress = 32'h010;
      tick();
      b4.memRequest = 0;
      tick(); tick();
      chk("l4 c3 done", 64'(b4.memDone), 64'd0);
      tick();
      chk("l4 c4 done", 64'(b4.memDone), 64'd1);
      chk("l4 c4 rdata", 64'(b4.memReadData), 64'h55667788);
      tick();
      b4.memRequest = 1;
      tick();
      b4.memRequest = 0;
      tick();
      rn4 = 0;
      tick();
      rn4 = 1;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (b4.memDone) seen = 1'b1;
         tick();
      end
      chk("l4 abort no done", 64'(seen), 64'd0);
      chk("l4 abort ready", 64'(b4.memReady), 64'd1);
      chk("l4 abort rdata", 64'(b4.memReadData), 64'd0);

      // 64-bit window 0x1000-0x10ff
      b64.memAddress = 32'h0FFF;
      #1;
      chk("w64 sel below", 64'(b64.memSelected), 64'd0);
      b64.memAddress = 32'h10FF;
      #1;
      chk("w64 sel top", 64'(b64.memSelected), 64'd1);
      b64.memRequest = 1; b64.memWrite = 1; b64.memAddress = 32'h1008;
      b64.memWriteData = 64'h0; b64.byteMask = 8'hFF;
      tick();
      b64.memWriteData = 64'h0123456789ABCDEF; b64.byteMask = 8'hF0;
      tick();
      b64.memRequest = 0;
      chk("w64 wr done", 64'(b64.memDone), 64'd1);
      tick();
      b64.memRequest = 1; b64.memWrite = 0; b64.memAddress = 32'h1008;
      tick();
      b64.memRequest = 0;
      chk("w64 rd done", 64'(b64.memDone), 64'd1);
      chk("w64 rd data", b64.memReadData, 64'h0123456700000000);
      tick();
      b64.memRequest = 1; b64.memWrite = 0; b64.memAddress = 32'h1004;
      tick();
      b64.memRequest = 0;
      chk("w64 misalign err", 64'(b64.memError), 64'd1);
      chk("w64 misalign data", b64.memReadData, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
